// File: rtl/manchester_decoder.sv
// manchester_decoder: serial pair-wise (Manchester) decoder.
// Captures a received string of up to 2*DW bits plus a length code, decodes one
// pair per clock and presents the decoded word together with a one-cycle done
// pulse. The block loops forever: LOAD -> DECODE (N cycles) -> DONE -> LOAD.
// Optional build macro MANCHESTER_DECODER_ERR_EN adds a sticky invalid-pair
// flag on output err, updated together with dstring.
module manchester_decoder #(
    parameter int DW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2*DW-1:0] rstring,
    input  logic [2:0]    size,
    output logic [DW-1:0] dstring,
    output logic          done
`ifdef MANCHESTER_DECODER_ERR_EN
    ,
    output logic          err
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_r;
    logic [2*DW-1:0]   rstring_r;
    logic [2:0]        n_r;
    logic [2:0]        idx_r;
    logic [DW-1:0]     work_r;
    logic [2:0]        n_s;
    logic [1:0]        pair_s;
    logic [DW-1:0]     work_next_s;
    logic              last_pair_s;
`ifdef MANCHESTER_DECODER_ERR_EN
    logic              err_flag_r;
`endif

    // 10 decodes to 1; 01 and the invalid codes 00/11 decode to 0.
    function automatic logic pair_to_bit(input logic [1:0] pair);
        logic bit_v;
        case (pair)
            2'b10:   bit_v = 1'b1;
            2'b01:   bit_v = 1'b0;
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    // A pair is invalid when both halves are equal (no mid-bit transition).
    function automatic logic pair_invalid(input logic [1:0] pair);
        return pair[1] ~^ pair[0];
    endfunction

    // Length code to data bit count; codes above 4 clamp to the full 7 bits.
    always_comb begin
        n_s = 3'd7;
        if (size > 3'd4) begin
            n_s = 3'd7;
        end else begin
            n_s = size + 3'd3;
        end
    end

    // Select the current pair and merge its decoded bit into the work word.
    always_comb begin
        pair_s      = 2'(rstring_r >> {idx_r, 1'b0});
        work_next_s = work_r | (DW'(pair_to_bit(pair_s)) << idx_r);
        last_pair_s = (idx_r == (n_r - 3'd1));
    end

    // Decoder state machine with registered result, done pulse and error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_LOAD;
            rstring_r  <= '0;
            n_r        <= 3'd0;
            idx_r      <= 3'd0;
            work_r     <= '0;
            dstring    <= '0;
            done       <= 1'b0;
`ifdef MANCHESTER_DECODER_ERR_EN
            err_flag_r <= 1'b0;
            err        <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_LOAD: begin
                    rstring_r  <= rstring;
                    n_r        <= n_s;
                    idx_r      <= 3'd0;
                    work_r     <= '0;
                    done       <= 1'b0;
`ifdef MANCHESTER_DECODER_ERR_EN
                    err_flag_r <= 1'b0;
`endif
                    state_r    <= ST_DECODE;
                end
                ST_DECODE: begin
                    work_r <= work_next_s;
                    done   <= 1'b0;
`ifdef MANCHESTER_DECODER_ERR_EN
                    err_flag_r <= err_flag_r | pair_invalid(pair_s);
`endif
                    if (last_pair_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + 3'd1;
                        state_r <= ST_DECODE;
                    end
                end
                ST_DONE: begin
                    dstring <= work_r;
                    done    <= 1'b1;
`ifdef MANCHESTER_DECODER_ERR_EN
                    err     <= err_flag_r;
`endif
                    state_r <= ST_LOAD;
                end
                default: begin
                    done    <= 1'b0;
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_decoder.sv
// tb_manchester_decoder: randomized scoreboard bench for manchester_decoder.
// The driver issues one transaction per result period and pushes the expected
// word (from a pair-table reference model) plus its due cycle; a monitor pops
// and compares whenever done is seen.
module tb_manchester_decoder;

    logic        clk;
    logic        rst;
    logic [13:0] rstring;
    logic [2:0]  size;
    logic [6:0]  dstring;
    logic        done;
`ifdef MANCHESTER_DECODER_ERR_EN
    logic        err;
`endif

    manchester_decoder #(.DW(7)) dut (
        .clk     (clk),
        .rst     (rst),
        .rstring (rstring),
        .size    (size),
        .dstring (dstring),
        .done    (done)
`ifdef MANCHESTER_DECODER_ERR_EN
        ,
        .err     (err)
`endif
    );

    typedef struct {
        logic [6:0] d;
        logic       e;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [6:0] last_d = 7'd0;
    logic       last_e = 1'b0;

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: data count from the length code, then pair table lookup.
    function automatic exp_t model(input logic [13:0] rs, input logic [2:0] sz);
        exp_t r;
        int   n;
        int   p;
        n   = (int'(sz) <= 4) ? int'(sz) + 3 : 7;
        r.d = 7'd0;
        r.e = 1'b0;
        for (int i = 0; i < n; i++) begin
            p = (int'(rs) / (4 ** i)) % 4;
            if (p == 2) r.d[i] = 1'b1;
            if (p == 0 || p == 3) r.e = 1'b1;
        end
        r.due = 0;
        return r;
    endfunction

    function automatic int nbits(input logic [2:0] sz);
        return (int'(sz) <= 4) ? int'(sz) + 3 : 7;
    endfunction

    // Drive one transaction at a negedge while the DUT sits in LOAD.
    // chg_at > 0: change inputs at that negedge after capture (must be ignored).
    // rst_at > 0: assert reset at that negedge after capture (result dropped).
    task automatic run_txn(input logic [13:0] rs, input logic [2:0] sz,
                           input int chg_at, input logic [13:0] rs2,
                           input logic [2:0] sz2, input int rst_at);
        exp_t x;
        int   n;
        n       = nbits(sz);
        rstring = rs;
        size    = sz;
        x       = model(rs, sz);
        x.due   = cyc + 1 + n + 1;
        q.push_back(x);
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            if (k == chg_at) begin
                rstring = rs2;
                size    = sz2;
            end
            if (k == rst_at) begin
                rst = 1'b0;
                q.delete();
                last_d = 7'd0;
                last_e = 1'b0;
                @(posedge clk);
                #1;
                chk("rst_dstring", int'(dstring), 0);
                chk("rst_done", int'(done), 0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
        end
    endtask

    // Monitor: pop and compare on done, check hold and timing otherwise.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: done=1 with no result expected (cycle %0d)", cyc);
                end else begin
                    x = q.pop_front();
                    chk("dstring", int'(dstring), int'(x.d));
                    chk("done_cycle", cyc, x.due);
`ifdef MANCHESTER_DECODER_ERR_EN
                    chk("err", int'(err), int'(x.e));
`endif
                    last_d = x.d;
                    last_e = x.e;
                end
            end else begin
                chk("hold_dstring", int'(dstring), int'(last_d));
`ifdef MANCHESTER_DECODER_ERR_EN
                chk("hold_err", int'(err), int'(last_e));
`endif
                if (q.size() > 0 && cyc > q[0].due) begin
                    checks++;
                    errors++;
                    $display("FAIL done_timeout: done=0 expected 1 by cycle %0d (cycle %0d)", q[0].due, cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Stimulus: directed cases first, then random traffic.
    initial begin
        logic [13:0] r1;
        logic [13:0] r2;
        logic [2:0]  s1;
        logic [2:0]  s2;
        rst     = 1'b0;
        rstring = 14'd0;
        size    = 3'd0;
        repeat (2) @(negedge clk);
        chk("reset_dstring", int'(dstring), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b1;

        run_txn(14'b11111001101011, 3'd3, 0, 14'd0, 3'd0, 0);
        run_txn(14'b00000000111111, 3'd0, 0, 14'd0, 3'd0, 0);
        run_txn(14'b10101010101010, 3'd4, 0, 14'd0, 3'd0, 0);
        run_txn(14'b10101010101010, 3'd7, 0, 14'd0, 3'd0, 0);
        run_txn(14'b01010101010101, 3'd4, 3, 14'b10101010101010, 3'd4, 0);
        run_txn(14'b10101010101010, 3'd4, 0, 14'd0, 3'd0, 0);
        run_txn(14'b10101010101010, 3'd4, 3, 14'd0, 3'd0, 3);
        run_txn(14'b01101001100110, 3'd2, 0, 14'd0, 3'd0, 0);

        for (int t = 0; t < 300; t++) begin
            r1 = 14'($urandom);
            s1 = 3'($urandom_range(0, 7));
            r2 = 14'($urandom);
            s2 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) begin
                run_txn(r1, s1, 2, r2, s2, $urandom_range(1, 4));
            end else begin
                run_txn(r1, s1, $urandom_range(0, 4), r2, s2, 0);
            end
        end

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
